// File: rtl/cmult_rr_sched_if.sv
// Requester operand bus and tagged response bus shared by cmult_rr_sched and its clients.
// The slave modport is the scheduler side; master is the requester/consumer side.
interface cmult_rr_sched_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a_re_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a_im_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b_re_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b_im_i;
    logic                          rsp_valid_o;
    logic [ID_W-1:0]               rsp_id_o;
    logic [DATA_WIDTH-1:0]         rsp_re_o;
    logic [DATA_WIDTH-1:0]         rsp_im_o;

    modport slave (
        input  req_valid_i,
        input  req_a_re_i,
        input  req_a_im_i,
        input  req_b_re_i,
        input  req_b_im_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_id_o,
        output rsp_re_o,
        output rsp_im_o
    );

    modport master (
        output req_valid_i,
        output req_a_re_i,
        output req_a_im_i,
        output req_b_re_i,
        output req_b_im_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_id_o,
        input  rsp_re_o,
        input  rsp_im_o
    );
endinterface

// File: rtl/cmult_rr_sched.sv
// Round-robin scheduler feeding one two-stage pipelined complex multiplier shared by NUM_REQ
// requesters; results are broadcast with the owner's tag exactly two edges after acceptance.
module cmult_rr_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    cmult_rr_sched_if.slave  bus,
    output logic             busy_o
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned PW   = 2 * DATA_WIDTH;

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_idx;
    logic            w_found;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_hs;

    // Descending scan so the smallest offset from the pointer is the one left standing.
    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_idx >= (ID_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (bus.req_valid_i[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_hs = enable_i & w_found;

    always_comb begin
        bus.req_ready_o = '0;
        if (w_hs) begin
            bus.req_ready_o[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            if (w_gnt_id == ID_W'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_id + ID_W'(1);
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

    assign w_a_re = bus.req_a_re_i[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_a_im = bus.req_a_im_i[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_re = bus.req_b_re_i[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_im = bus.req_b_im_i[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];

    logic                  r_s1_valid;
    logic [ID_W-1:0]       r_s1_id;
    logic [DATA_WIDTH-1:0] r_s1_a_re, r_s1_a_im, r_s1_b_re, r_s1_b_im;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a_re  <= '0;
            r_s1_a_im  <= '0;
            r_s1_b_re  <= '0;
            r_s1_b_im  <= '0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_id   <= w_gnt_id;
                r_s1_a_re <= w_a_re;
                r_s1_a_im <= w_a_im;
                r_s1_b_re <= w_b_re;
                r_s1_b_im <= w_b_im;
            end
        end
    end

    // Complex multiply keeping only the upper half of each full-width unsigned product.
    logic [PW-1:0]         w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic [DATA_WIDTH-1:0] w_re, w_im;

    assign w_p_rr = PW'(r_s1_a_re) * PW'(r_s1_b_re);
    assign w_p_ii = PW'(r_s1_a_im) * PW'(r_s1_b_im);
    assign w_p_ri = PW'(r_s1_a_re) * PW'(r_s1_b_im);
    assign w_p_ir = PW'(r_s1_a_im) * PW'(r_s1_b_re);
    assign w_re   = w_p_rr[PW-1:DATA_WIDTH] - w_p_ii[PW-1:DATA_WIDTH];
    assign w_im   = w_p_ri[PW-1:DATA_WIDTH] + w_p_ir[PW-1:DATA_WIDTH];

    logic                  r_s2_valid;
    logic [ID_W-1:0]       r_s2_id;
    logic [DATA_WIDTH-1:0] r_s2_re, r_s2_im;

    // Payload only loads behind a valid entry so idle outputs keep the last result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_re    <= '0;
            r_s2_im    <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_id <= r_s1_id;
                r_s2_re <= w_re;
                r_s2_im <= w_im;
            end
        end
    end

    assign bus.rsp_valid_o = r_s2_valid;
    assign bus.rsp_id_o    = r_s2_id;
    assign bus.rsp_re_o    = r_s2_re;
    assign bus.rsp_im_o    = r_s2_im;
    assign busy_o          = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_cmult_rr_sched.sv
// Directed bench for cmult_rr_sched: stimulus pushes hand-computed responses into a queue and
// an independent monitor pops and compares them, including their arrival cycle.
module tb_cmult_rr_sched;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    cmult_rr_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    cmult_rr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .enable_i(enable),
        .bus     (bus),
        .busy_o  (busy)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Table operands: a=((i+1)*0x1000, 0x1000), b=(0x8000, 0x4000).
    logic [DW-1:0] t_re[NR] = '{16'h0400, 16'h0C00, 16'h1400, 16'h1C00};
    logic [DW-1:0] t_im[NR] = '{16'h0C00, 16'h1000, 16'h1400, 16'h1800};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_id_o), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
                chk("rsp_re", 32'(bus.rsp_re_o), 32'(e.re));
                chk("rsp_im", 32'(bus.rsp_im_o), 32'(e.im));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic set_req(input int i, input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                           input logic [DW-1:0] br, input logic [DW-1:0] bi);
        bus.req_a_re_i[i*DW +: DW] = ar;
        bus.req_a_im_i[i*DW +: DW] = ai;
        bus.req_b_re_i[i*DW +: DW] = br;
        bus.req_b_im_i[i*DW +: DW] = bi;
    endtask

    task automatic load_table();
        for (int i = 0; i < NR; i++) begin
            set_req(i, DW'((i + 1) * 'h1000), 16'h1000, 16'h8000, 16'h4000);
        end
    endtask

    // One cycle: check the grant and, on a handshake, queue the result due two edges later.
    task automatic step(input logic [NR-1:0] exp_rdy, input int id,
                        input logic [DW-1:0] e_re, input logic [DW-1:0] e_im);
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
        if (exp_rdy != '0) sb.push_back('{id, e_re, e_im, cyc + 2});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid_i = '0;
        bus.req_a_re_i  = '0;
        bus.req_a_im_i  = '0;
        bus.req_b_re_i  = '0;
        bus.req_b_im_i  = '0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id_o), 32'd0);
        chk("rst_rsp_re", 32'(bus.rsp_re_o), 32'd0);
        chk("rst_rsp_im", 32'(bus.rsp_im_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 2, busy for exactly two cycles.
        set_req(2, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
        bus.req_valid_i = 4'b0100;
        step(4'b0100, 2, 16'h4000, 16'h0000);
        bus.req_valid_i = '0;
        @(negedge clk) chk("busy_s1", 32'(busy), 32'd1);
        @(negedge clk) chk("busy_s2", 32'(busy), 32'd1);
        @(negedge clk) chk("busy_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Arithmetic wrap cases, back to back from requester 1 (pointer 3 -> 2 -> 2).
        set_req(1, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003);
        bus.req_valid_i = 4'b0010;
        step(4'b0010, 1, 16'h0001, 16'h0002);
        set_req(1, 16'h0000, 16'h8000, 16'h0000, 16'h8000);
        step(4'b0010, 1, 16'hC000, 16'h0000);

        // Requester 3 alone moves the pointer to 0 via the wrap.
        load_table();
        bus.req_valid_i = 4'b1000;
        step(4'b1000, 3, t_re[3], t_im[3]);

        // Fairness: all valid for 8 cycles.
        bus.req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(NR'(1 << (k % NR)), k % NR, t_re[k % NR], t_im[k % NR]);
        end
        bus.req_valid_i = '0;

        // Pointer to 3, then only 1 and 3 valid.
        bus.req_valid_i = 4'b0100;
        step(4'b0100, 2, t_re[2], t_im[2]);
        bus.req_valid_i = 4'b1010;
        step(4'b1000, 3, t_re[3], t_im[3]);
        step(4'b0010, 1, t_re[1], t_im[1]);
        step(4'b1000, 3, t_re[3], t_im[3]);
        bus.req_valid_i = '0;

        // Enable low for 3 cycles while two accepted entries drain.
        bus.req_valid_i = 4'b1111;
        step(4'b0001, 0, t_re[0], t_im[0]);
        step(4'b0010, 1, t_re[1], t_im[1]);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) step('0, 0, '0, '0);
        enable = 1'b1;
        step(4'b0100, 2, t_re[2], t_im[2]);
        bus.req_valid_i = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with both stages full; these two entries must never surface.
        bus.req_valid_i = 4'b1111;
        @(negedge clk) chk("mid_ready_a", 32'(bus.req_ready_o), 32'(4'b1000));
        @(posedge clk);
        #1;
        @(negedge clk) chk("mid_ready_b", 32'(bus.req_ready_o), 32'(4'b0001));
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) chk("post_rst_quiet", 32'(bus.rsp_valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 4'b1111;
        step(4'b0001, 0, t_re[0], t_im[0]);
        bus.req_valid_i = '0;

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmult_rr_sched.md
Name: cmult_rr_sched

Overview:
- Shares one pipelined complex multiplier among NUM_REQ requesters.
- A round-robin arbiter accepts at most one operand set per cycle and tags it with the requester index.
- The operands pass through two register stages around the team's combinational complex_mult datapath.
- The result is broadcast on a single response bus with its tag, at a fixed latency and with no response backpressure.

Parameters:
- DATA_WIDTH, 16, width of each real/imag operand and result component.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived, not overridden).

Ports:
- clk_i  in  1  clock, all state on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  grant enable; when low, no new request is accepted and the pipeline still drains
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a_re_i  in  NUM_REQ*DATA_WIDTH  packed operand a real; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_a_im_i, req_b_re_i, req_b_im_i  in  NUM_REQ*DATA_WIDTH  same packing as req_a_re_i
- rsp_valid_o  out  1  result valid (single-cycle pulse per accepted request)
- rsp_id_o  out  ID_W  index of the requester that owns the result
- rsp_re_o  out  DATA_WIDTH  result real part
- rsp_im_o  out  DATA_WIDTH  result imaginary part
- busy_o  out  1  high while either pipeline stage holds a valid entry

Behaviour:
- Reset (asynchronous, on rst_ni low): priority pointer=0; stage-1 and stage-2 valid=0; rsp_valid_o=0, rsp_id_o=0, rsp_re_o=0, rsp_im_o=0, busy_o=0. Data registers clear to 0.
- Arbitration (combinational):
  - Search from the priority pointer upward, wrapping modulo NUM_REQ; the first i with req_valid_i[i]=1 is granted.
  - req_ready_o[i]=1 only for the granted i, and only when enable_i=1.
  - req_ready_o may depend on req_valid_i in the same cycle; requesters must not make valid depend on ready.
- Handshake: a transfer occurs on an edge where req_valid_i[i] && req_ready_o[i].
  - A requester keeps valid and operands stable until it sees ready.
  - Valid deasserted without a handshake is legal; nothing is captured.
- Pointer update: on a handshake to i, pointer <= (i+1) mod NUM_REQ. With no handshake, the pointer holds.
  - Wrap: a grant to NUM_REQ-1 sets the pointer to 0.
  - A lone active requester is granted every cycle.
- Stage 1 (handshake edge E): captures the four operands of the granted requester, its ID, and s1_valid=1. With no handshake, s1_valid<=0.
- Stage 2 (edge E+1): captures the complex_mult result of the stage-1 operands, the ID, and s2_valid<=s1_valid. rsp_* are driven directly from the stage-2 registers.
- Latency and throughput:
  - rsp_valid_o is high for exactly the cycle following edge E+1, i.e. 2 edges after the handshake.
  - Throughput is 1 result per cycle. Results return in acceptance order.
- Arithmetic (bit-exact with complex_mult):
  - Operands are unsigned DATA_WIDTH.
  - Each product is a full 2*DATA_WIDTH unsigned product; hi(x) is its upper DATA_WIDTH bits.
  - rsp_re = (hi(a_re*b_re) - hi(a_im*b_im)) mod 2^DATA_WIDTH.
  - rsp_im = (hi(a_re*b_im) + hi(a_im*b_re)) mod 2^DATA_WIDTH.
  - No rounding, no saturation.
- Hold when idle: when s2_valid=0, rsp_re_o, rsp_im_o and rsp_id_o hold their last value. Consumers qualify them with rsp_valid_o.
- busy_o = s1_valid | s2_valid (registered state, no combinational input path).
- enable_i low: req_ready_o=0 for all requesters; in-flight entries still emerge on schedule; the pointer holds.
- Reset mid-operation: in-flight entries are discarded. rsp_valid_o drops asynchronously and no stale result appears after reset release.

Test Plan:
- Single request, DATA_WIDTH=16, requester 2: a=(0x8000,0x0000), b=(0x8000,0x0000) -> 2 edges later rsp_valid_o=1 for 1 cycle, rsp_id_o=2, rsp_re_o=0x4000, rsp_im_o=0x0000; busy_o high for 2 cycles.
- Arithmetic wrap: a=(0xFFFF,0x0001), b=(0x0002,0x0003) -> rsp_re_o=0x0001, rsp_im_o=0x0002. Also a=(0x0000,0x8000), b=(0x0000,0x8000) -> rsp_re_o=0xC000 (0-0x4000 mod 2^16).
- Round-robin fairness: NUM_REQ=4, all req_valid_i held high for 8 cycles -> grants and rsp_id_o sequence 0,1,2,3,0,1,2,3; one response per cycle; no gaps.
- Pointer wrap and skip: pointer at 3, only requesters 1 and 3 valid -> grant 3, then 1, then 3; requesters 0 and 2 are never readied.
- enable_i low for 3 cycles with all requests valid -> req_ready_o=0 throughout; the 2 previously accepted results still emerge; the pointer is unchanged on re-enable.
- Reset mid-flight: assert rst_ni low with both stages valid -> rsp_valid_o=0 and busy_o=0 immediately. After release with no requests, no rsp_valid_o pulse occurs; the first new grant goes to requester 0.
